strip_scan_sequencer: RTL and testbench

- Automated scan controller for the comparator test datapath. It steps the pulse multiplexer across a strip range and fires a programmed number of pulses per strip through the pulser handshake.
- After each pulse it checks the captured halfstrips and compout against their expected values and records a per-strip fail mask.
- It sits between the serial register interface (config, start, status) and the pulser/comparator injector. Everything is in the 40 MHz domain.

---
 rtl/strip_scan_sequencer.sv | 146 ++++++++++++++
 tb/tb_strip_scan_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/strip_scan_sequencer.sv
// Strip scan sequencer: steps the pulse mux across a strip range, fires npulses per strip
// and records a per-strip fail mask. Optional macro SEQ_STOP_ON_FAIL_EN ends the scan at the first failure.
module strip_scan_sequencer #(
  parameter int NSTRIP         = 16,
  parameter int SETTLE_CYCLES  = 64,
  parameter int READOUT_CYCLES = 8,
  parameter int TIMEOUT_CYCLES = 1023,
  localparam int SW            = $clog2(NSTRIP)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [SW-1:0]     strip_first,
  input  logic [SW-1:0]     strip_last,
  input  logic [15:0]       npulses,
  input  logic              pulser_ready,
  output logic              fire_pulse,
  input  logic [31:0]       halfstrips,
  input  logic [31:0]       halfstrips_expect,
  input  logic              compout,
  input  logic              compout_expect,
  output logic [NSTRIP-1:0] mux_sel,
  output logic              errcnt_rst,
  output logic              busy,
  output logic              done,
  output logic [SW-1:0]     cur_strip,
  output logic [NSTRIP-1:0] fail_mask,
  output logic              timeout_err,
  output logic [3:0]        dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef SEQ_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SELECT  = 4'd1,
    S_SETTLE  = 4'd2,
    S_ARM     = 4'd3,
    S_FIRE    = 4'd4,
    S_READOUT = 4'd5,
    S_CHECK   = 4'd6,
    S_NEXT    = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [15:0]   pcnt_q, np_q, pcnt_inc;
  logic [SW-1:0] cur_q, last_q;
  logic          mismatch, arm_tmo, aborting;

  assign mismatch = (halfstrips != halfstrips_expect) || (compout != compout_expect);
  assign arm_tmo  = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign pcnt_inc = pcnt_q + 16'd1;
  assign aborting = abort && (state_q != S_IDLE);

  // Pulser handshake: pulser_ready is a level "idle/armed" indication sampled in ARM;
  // the cycle after it is seen high, fire_pulse is driven for exactly one clock.
  always_comb begin
    state_d = state_q;
    if (aborting) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (start) state_d = (strip_first > strip_last) ? S_DONE : S_SELECT;
        S_SELECT:  state_d = S_SETTLE;
        S_SETTLE:  if (cnt_q == CW'(SETTLE_CYCLES - 1)) state_d = (np_q == '0) ? S_NEXT : S_ARM;
        S_ARM: begin
          if (pulser_ready)  state_d = S_FIRE;
          else if (arm_tmo)  state_d = STOP_ON_FAIL ? S_DONE : S_NEXT;
        end
        S_FIRE:    state_d = S_READOUT;
        S_READOUT: if (cnt_q == CW'(READOUT_CYCLES - 1)) state_d = S_CHECK;
        S_CHECK: begin
          if (STOP_ON_FAIL && mismatch) state_d = S_DONE;
          else if (pcnt_inc < np_q)     state_d = S_ARM;
          else                          state_d = S_NEXT;
        end
        S_NEXT:    state_d = (cur_q == last_q) ? S_DONE : S_SELECT;
        S_DONE:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      pcnt_q      <= '0;
      np_q        <= '0;
      cur_q       <= '0;
      last_q      <= '0;
      fail_mask   <= '0;
      timeout_err <= 1'b0;
      errcnt_rst  <= 1'b0;
    end else begin
      errcnt_rst <= 1'b0;
      // One shared cycle counter, restarted on every state change.
      if (state_d != state_q || state_q == S_IDLE) cnt_q <= '0;
      else                                          cnt_q <= cnt_q + CW'(1);
      if (!aborting) begin
        case (state_q)
          S_IDLE: if (start) begin
            cur_q       <= strip_first;
            last_q      <= strip_last;
            np_q        <= npulses;
            fail_mask   <= '0;
            timeout_err <= 1'b0;
            errcnt_rst  <= 1'b1;
          end
          S_SELECT: pcnt_q <= '0;
          S_ARM: if (!pulser_ready && arm_tmo) begin
            timeout_err      <= 1'b1;
            fail_mask[cur_q] <= 1'b1;
          end
          S_CHECK: begin
            if (mismatch) fail_mask[cur_q] <= 1'b1;
            pcnt_q <= pcnt_inc;
          end
          S_NEXT: if (cur_q != last_q) cur_q <= cur_q + SW'(1);
          default: ;
        endcase
      end
    end
  end

  assign fire_pulse = (state_q == S_FIRE);
  assign done       = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign mux_sel    = busy ? ({{(NSTRIP-1){1'b0}}, 1'b1} << cur_q) : '0;
  assign cur_strip  = cur_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_strip_scan_sequencer.sv
// Bench for strip_scan_sequencer: randomized scans against a strip/pulse-level reference model,
// with an event scoreboard (errcnt_rst, fire_pulse, done) plus directed corner cases.
`timescale 1ns/1ps
module tb_strip_scan_sequencer;
  localparam int W = 24;
`ifdef SEQ_STOP_ON_FAIL_EN
  localparam bit STOP_MODE = 1'b1;
`else
  localparam bit STOP_MODE = 1'b0;
`endif

  logic        clk = 1'b0, reset, start, abort;
  logic [3:0]  strip_first, strip_last, cur_strip, dbg_state;
  logic [15:0] npulses, mux_sel, fail_mask;
  logic        pulser_ready, fire_pulse, compout, compout_expect;
  logic [31:0] halfstrips, halfstrips_expect;
  logic        errcnt_rst, busy, done, timeout_err;

  logic [W-1:0] exp_q[$];
  int  vectors = 0, miscompares = 0, done_cnt = 0, fire_cnt = 0;
  bit  mon_en = 1'b0, ready_always = 1'b0;
  bit  bad[16], bad_kind[16], dead[16];

  strip_scan_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .strip_first(strip_first), .strip_last(strip_last), .npulses(npulses),
    .pulser_ready(pulser_ready), .fire_pulse(fire_pulse),
    .halfstrips(halfstrips), .halfstrips_expect(halfstrips_expect),
    .compout(compout), .compout_expect(compout_expect),
    .mux_sel(mux_sel), .errcnt_rst(errcnt_rst), .busy(busy), .done(done),
    .cur_strip(cur_strip), .fail_mask(fail_mask), .timeout_err(timeout_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #12.5 clk = ~clk;

  initial begin
    #2400000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ev_err(input bit nonempty, input int first);
    return {2'd0, 1'b0, nonempty, 4'(first), 16'h0000};
  endfunction

  function automatic logic [W-1:0] ev_fire(input logic tmo, input int s);
    logic [15:0] m;
    m = 16'h0001 << s;
    return {2'd1, tmo, 1'b1, 4'(s), m};
  endfunction

  function automatic logic [W-1:0] ev_done(input logic [15:0] mask, input logic tmo, input int cur);
    return {2'd2, tmo, 1'b0, 4'(cur), mask};
  endfunction

  function automatic void check_evt(input string name, input logic [W-1:0] act);
    logic [W-1:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: unexpected event 0x%0h, none expected", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        miscompares++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, e);
      end
    end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (errcnt_rst) check_evt("errcnt_evt", {2'd0, timeout_err, busy, cur_strip, fail_mask});
      if (fire_pulse) begin
        fire_cnt++;
        check_evt("fire_evt", {2'd1, timeout_err, busy, cur_strip, mux_sel});
      end
      if (done) begin
        done_cnt++;
        check_evt("done_evt", {2'd2, timeout_err, busy, cur_strip, fail_mask});
      end
    end
  end

  // ---------------- pulser / comparator environment ----------------
  task automatic env_drive();
    int s;
    s = -1;
    for (int i = 0; i < 16; i++) if (mux_sel[i]) s = i;
    halfstrips_expect = $urandom;
    compout_expect    = 1'($urandom_range(0, 1));
    halfstrips        = halfstrips_expect;
    compout           = compout_expect;
    pulser_ready      = ready_always || ($urandom_range(0, 3) != 0);
    if (s >= 0) begin
      if (dead[s]) pulser_ready = 1'b0;
      if (bad[s]) begin
        if (bad_kind[s]) halfstrips = halfstrips_expect ^ (32'h1 << $urandom_range(0, 31));
        else             compout = ~compout_expect;
      end
    end
  endtask

  initial begin
    pulser_ready = 1'b0; halfstrips = '0; halfstrips_expect = '0;
    compout = 1'b0; compout_expect = 1'b0;
    forever begin
      @(posedge clk); #2;
      env_drive();
    end
  end

  // ---------------- reference model: strip/pulse-level scan outcome ----------------
  task automatic model_scan(input int first, input int last, input int np);
    logic [15:0] mask;
    logic        tmo;
    int          cur;
    bit          stop;
    mask = '0; tmo = 1'b0; cur = first; stop = 1'b0;
    exp_q.push_back(ev_err(first <= last, first));
    if (first <= last) begin
      for (int s = first; s <= last && !stop; s++) begin
        cur = s;
        if (np == 0) continue;
        if (dead[s]) begin
          mask[s] = 1'b1; tmo = 1'b1; stop = STOP_MODE;
          continue;
        end
        for (int p = 0; p < np && !stop; p++) begin
          exp_q.push_back(ev_fire(tmo, s));
          if (bad[s]) begin mask[s] = 1'b1; stop = STOP_MODE; end
        end
      end
    end
    exp_q.push_back(ev_done(mask, tmo, cur));
  endtask

  // ---------------- drivers ----------------
  task automatic clear_env();
    for (int i = 0; i < 16; i++) begin bad[i] = 0; dead[i] = 0; bad_kind[i] = 0; end
  endtask

  task automatic run_scan(input int first, input int last, input int np);
    int d0, budget;
    model_scan(first, last, np);
    d0 = done_cnt;
    @(posedge clk); #1;
    strip_first = 4'(first); strip_last = 4'(last); npulses = 16'(np); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (first > last) chk("empty_done_latency", done, 1);
    // config changes and a stray start while busy must not disturb the scan
    strip_first = 4'($urandom); strip_last = 4'($urandom); npulses = 16'($urandom);
    repeat ($urandom_range(3, 40)) @(posedge clk);
    #1;
    if (busy) begin start = 1'b1; @(posedge clk); #1; start = 1'b0; end
    budget = 0;
    while (done_cnt == d0 && budget < 20000) begin @(posedge clk); budget++; end
    chk("done_seen", done_cnt != d0, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int f0, d0, budget, f, l, np;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    strip_first = '0; strip_last = '0; npulses = '0;
    clear_env();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fire_pulse", fire_pulse, 0);
    chk("rst_mux_sel", mux_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_errcnt_rst", errcnt_rst, 0);
    chk("rst_cur_strip", cur_strip, 0);
    chk("rst_fail_mask", fail_mask, 0);
    chk("rst_timeout_err", timeout_err, 0);
    reset = 1'b0; mon_en = 1'b1;

    // all good, strips 0..3, two pulses each
    ready_always = 1'b1;
    f0 = fire_cnt;
    run_scan(0, 3, 2);
    chk("good_fire_count", fire_cnt - f0, 8);
    chk("good_fail_mask", fail_mask, 16'h0000);

    // mismatch on strip 2 only
    bad[2] = 1; bad_kind[2] = 1;
    run_scan(0, 3, 2);
    chk("bad2_fail_mask", fail_mask, 16'h0004);
    chk("bad2_cur_strip", cur_strip, STOP_MODE ? 2 : 3);
    clear_env();

    // pulser never ready on strip 1
    dead[1] = 1;
    run_scan(0, 3, 1);
    chk("dead1_timeout_err", timeout_err, 1);
    chk("dead1_fail_mask", fail_mask, 16'h0002);
    clear_env();

    // empty range and zero pulses
    f0 = fire_cnt;
    run_scan(5, 4, 3);
    chk("empty_fail_mask", fail_mask, 0);
    run_scan(0, 1, 0);
    chk("np0_fire_count", fire_cnt - f0, 0);
    chk("np0_fail_mask", fail_mask, 0);

    // abort during READOUT of strip 7
    if (!STOP_MODE) begin bad[6] = 1; bad_kind[6] = 0; end
    exp_q.push_back(ev_err(1, 6));
    exp_q.push_back(ev_fire(0, 6));
    exp_q.push_back(ev_fire(0, 6));
    exp_q.push_back(ev_fire(0, 7));
    d0 = done_cnt;
    @(posedge clk); #1;
    strip_first = 4'd6; strip_last = 4'd9; npulses = 16'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    budget = 0;
    while (!(fire_pulse && mux_sel == 16'h0080) && budget < 2000) begin @(posedge clk); #1; budget++; end
    chk("abort_reach_strip7", budget < 2000, 1);
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_mux_sel", mux_sel, 0);
    chk("abort_fire_pulse", fire_pulse, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_fail_mask", fail_mask, STOP_MODE ? 16'h0000 : 16'h0040);
    chk("abort_queue", exp_q.size(), 0);
    exp_q.delete();
    clear_env();
    run_scan(7, 8, 1);

    // asynchronous reset while fire_pulse is high
    mon_en = 1'b0;
    @(posedge clk); #1;
    strip_first = 4'd0; strip_last = 4'd0; npulses = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    budget = 0;
    while (!fire_pulse && budget < 2000) begin @(posedge clk); #1; budget++; end
    chk("rstfire_reach", fire_pulse, 1);
    #2 reset = 1'b1;
    #1;
    chk("rstfire_fire_pulse", fire_pulse, 0);
    chk("rstfire_busy", busy, 0);
    chk("rstfire_mux_sel", mux_sel, 0);
    @(posedge clk); #1;
    reset = 1'b0; mon_en = 1'b1;

    // randomized scans
    ready_always = 1'b0;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 16; i++) begin
        bad[i]      = ($urandom_range(0, 4) == 0);
        bad_kind[i] = 1'($urandom_range(0, 1));
        dead[i]     = ($urandom_range(0, 24) == 0);
      end
      f = $urandom_range(0, 15);
      l = f + $urandom_range(0, 5) - 1;
      if (l > 15) l = 15;
      if (l < 0) l = 0;
      np = $urandom_range(0, 3);
      run_scan(f, l, np);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
